// File: rtl/gcd_controller.sv
// Control FSM for the 8-bit subtractive GCD datapath.
// Optional iteration-limit watchdog enabled by defining GCD_TIMEOUT_EN.
module gcd_controller #(
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a_gt_b,
  input  logic a_eq_b,
  input  logic a_lt_b,
  output logic a_sel,
  output logic b_sel,
  output logic a_ld,
  output logic b_ld,
  output logic output_en,
  output logic ready,
  output logic busy,
  output logic done,
  output logic error
);

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDone} state_e;

  state_e state_q, state_d;

`ifdef GCD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             step;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_ITER), 32'(CNT_W)};
`endif

  always_comb begin
    state_d   = state_q;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    output_en = 1'b0;
`ifdef GCD_TIMEOUT_EN
    abort_d   = 1'b0;
    step      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        a_sel   = 1'b1;
        b_sel   = 1'b1;
        a_ld    = 1'b1;
        b_ld    = 1'b1;
        state_d = StCompute;
      end
      StCompute: begin
        if (a_eq_b) begin
          output_en = 1'b1;
          state_d   = StDone;
`ifdef GCD_TIMEOUT_EN
        end else if (cnt_q == MaxIter) begin
          // Watchdog abort: no loads, out register keeps its prior value.
          abort_d = 1'b1;
          state_d = StDone;
`endif
        end else if (a_gt_b) begin
          a_ld = 1'b1;
`ifdef GCD_TIMEOUT_EN
          step = 1'b1;
`endif
        end else if (a_lt_b) begin
          b_ld = 1'b1;
`ifdef GCD_TIMEOUT_EN
          step = 1'b1;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef GCD_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StLoad) begin
      cnt_d = '0;
    end else if (step && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
`ifdef GCD_TIMEOUT_EN
      cnt_q   <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef GCD_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
`endif
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
`ifdef GCD_TIMEOUT_EN
  // abort_q is only set on the COMPUTE->DONE edge, so it pulses with done.
  assign error = abort_q;
`else
  assign error = 1'b0;
`endif

endmodule
